// File: rtl/bfly_25_unified_pkg.sv
// Shared constants for the 25-bit NTT/INTT butterfly.
//   Q        modulus 33292289 (= 2^25 - 2^18 + 1)
//   QW       coefficient width
//   LAT      input-to-output latency in clocks
//   RED_LAT  latency of the Reduc_25_s reducer
//   MODE_*   butterfly mode encodings
package bfly_25_unified_pkg;

   localparam int unsigned QW      = 25;
   localparam int unsigned LAT     = 9;
   localparam int unsigned RED_LAT = 5;

   localparam logic [QW-1:0] Q     = 25'd33292289;
   // Q widened by one bit for the 26-bit add/sub correction
   localparam logic [QW:0]   Q_EXT = {1'b0, Q};

   localparam logic MODE_CT = 1'b0;
   localparam logic MODE_GS = 1'b1;

   typedef logic [QW-1:0] coef_t;

endpackage

// File: rtl/Reduc_25_s.sv
// Five-stage modular reducer: 50-bit value -> value mod 33292289.
//   clk        system clock
//   rst        reset, synchronous active-high (clears on a clk edge with rst high)
//   en         Din valid
//   Din        50-bit input, expected < q^2
//   Dout       reduced result in [0, q)
//   Dout_flag  Dout valid, five clocks after en
// Uses 2^25 == 2^18 - 1 (mod q): each fold replaces hi*2^25 with (hi<<18) - hi,
// shrinking the value until a final subtract of 0, q or 2q.
module Reduc_25_s (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [49:0] Din,
   output logic [24:0] Dout,
   output logic        Dout_flag
);

   localparam logic [26:0] QR  = 27'd33292289;
   localparam logic [26:0] QR2 = 27'd66584578;

   logic [43:0] s1_d, s1_q;
   logic [37:0] s2_d, s2_q;
   logic [31:0] s3_d, s3_q;
   logic [26:0] s4_d, s4_q;
   logic [24:0] dout_d;
   logic [3:0]  flag_d, flag_q;

   always_comb begin
      s1_d = ({19'd0, Din[49:25]} << 18) - {19'd0, Din[49:25]} + {19'd0, Din[24:0]};
      s2_d = ({19'd0, s1_q[43:25]} << 18) - {19'd0, s1_q[43:25]} + {13'd0, s1_q[24:0]};
      s3_d = ({19'd0, s2_q[37:25]} << 18) - {19'd0, s2_q[37:25]} + {7'd0, s2_q[24:0]};
      s4_d = ({20'd0, s3_q[31:25]} << 18) - {20'd0, s3_q[31:25]} + {2'd0, s3_q[24:0]};
      // s4 < 3q after the last fold
      if (s4_q >= QR2) begin
         dout_d = 25'(s4_q - QR2);
      end else if (s4_q >= QR) begin
         dout_d = 25'(s4_q - QR);
      end else begin
         dout_d = s4_q[24:0];
      end
      flag_d = {flag_q[2:0], en};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         s4_q      <= '0;
         flag_q    <= '0;
         Dout      <= '0;
         Dout_flag <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s3_q      <= s3_d;
         s4_q      <= s4_d;
         flag_q    <= flag_d;
         Dout      <= dout_d;
         Dout_flag <= flag_q[3];
      end
   end

endmodule

// File: rtl/mul_25x25_p2.sv
// Two-stage registered 25x25 unsigned multiplier.
//   clk    system clock
//   rst    asynchronous active-high reset
//   x_in   25-bit multiplicand
//   y_in   25-bit multiplier
//   p_out  50-bit product, registered, two clocks after x_in/y_in
// Stage 1 registers two partial products (y split 13/12 bits), stage 2 sums them.
module mul_25x25_p2 (
   input  logic        clk,
   input  logic        rst,
   input  logic [24:0] x_in,
   input  logic [24:0] y_in,
   output logic [49:0] p_out
);

   logic [37:0] pp_lo_d, pp_lo_q;
   logic [36:0] pp_hi_d, pp_hi_q;
   logic [49:0] p_d, p_q;

   always_comb begin
      pp_lo_d = {13'd0, x_in} * {25'd0, y_in[12:0]};
      pp_hi_d = {12'd0, x_in} * {25'd0, y_in[24:13]};
      p_d     = {12'd0, pp_lo_q} + {pp_hi_q, 13'd0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pp_lo_q <= '0;
         pp_hi_q <= '0;
         p_q     <= '0;
      end else begin
         pp_lo_q <= pp_lo_d;
         pp_hi_q <= pp_hi_d;
         p_q     <= p_d;
      end
   end

   assign p_out = p_q;

endmodule

// File: rtl/bfly_25_unified.sv
// Pipelined CT/GS butterfly over Z_q, one butterfly per clock, 9-clock latency.
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         input sample valid
//   mode       0 = CT (a + w*b, a - w*b), 1 = GS (a + b, (a - b)*w)
//   a_in/b_in  operands, < Q
//   w_in       twiddle, < Q
//   out_a/b    results in [0, Q), zero whenever Dout_flag is low
//   Dout_flag  out_a/out_b valid
// Pipeline: P (pre-add/sub) -> M1,M2 (multiply) -> R1..R5 (Reduc_25_s) -> O (post add/sub).
module bfly_25_unified
   import bfly_25_unified_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          mode,
   input  logic [QW-1:0] a_in,
   input  logic [QW-1:0] b_in,
   input  logic [QW-1:0] w_in,
   output logic [QW-1:0] out_a,
   output logic [QW-1:0] out_b,
   output logic          Dout_flag
);

   localparam int unsigned PIPE_D   = LAT - 1;             // valid bits before stage O
   localparam int unsigned PROD_IDX = 2;                   // product register valid
   localparam int unsigned RED_IDX  = PROD_IDX + RED_LAT;  // reducer output valid
   localparam int unsigned SIDE_D   = RED_IDX + 1;         // [0] is stage P

   function automatic coef_t mod_add(input coef_t x, input coef_t y);
      logic [QW:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= Q_EXT) begin
         s = s - Q_EXT;
      end
      return s[QW-1:0];
   endfunction

   function automatic coef_t mod_sub(input coef_t x, input coef_t y);
      logic [QW:0] d;
      d = {1'b0, x} - {1'b0, y};
      // bit QW is the sign of the 26-bit difference
      if (d[QW]) begin
         d = d + Q_EXT;
      end
      return d[QW-1:0];
   endfunction

   logic [PIPE_D-1:0] vld_d, vld_q;
   logic [SIDE_D-1:0] mode_d, mode_q;
   coef_t             side_d [SIDE_D];
   coef_t             side_q [SIDE_D];
   coef_t             mulx_d, mulx_q;
   coef_t             w_d, w_q;
   logic [2*QW-1:0]   prod;
   coef_t             red_dout;
   logic              red_flag;
   coef_t             out_a_d, out_a_q;
   coef_t             out_b_d, out_b_q;
   logic              flag_d, flag_q;

   always_comb begin
      vld_d     = {vld_q[PIPE_D-2:0], en};
      mode_d    = {mode_q[SIDE_D-2:0], mode};
      side_d[0] = (mode == MODE_GS) ? mod_add(a_in, b_in) : a_in;
      for (int unsigned i = 1; i < SIDE_D; i++) begin
         side_d[i] = side_q[i-1];
      end
      mulx_d = (mode == MODE_GS) ? mod_sub(a_in, b_in) : b_in;
      w_d    = w_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         mode_q <= '0;
         side_q <= '{default: '0};
         mulx_q <= '0;
         w_q    <= '0;
      end else begin
         vld_q  <= vld_d;
         mode_q <= mode_d;
         side_q <= side_d;
         mulx_q <= mulx_d;
         w_q    <= w_d;
      end
   end

   mul_25x25_p2 u_mul (
      .clk   (clk),
      .rst   (rst),
      .x_in  (mulx_q),
      .y_in  (w_q),
      .p_out (prod)
   );

   Reduc_25_s u_reduc (
      .clk       (clk),
      .rst       (rst),
      .en        (vld_q[PROD_IDX]),
      .Din       (prod),
      .Dout      (red_dout),
      .Dout_flag (red_flag)
   );

   // Local valid pipe is authoritative; the reducer's flag must track it.
   a_red_flag_align: assert property (@(posedge clk) disable iff (rst)
      red_flag == vld_q[RED_IDX]);

   always_comb begin
      flag_d  = vld_q[RED_IDX];
      out_a_d = '0;
      out_b_d = '0;
      if (vld_q[RED_IDX]) begin
         if (mode_q[RED_IDX] == MODE_GS) begin
            out_a_d = side_q[RED_IDX];
            out_b_d = red_dout;
         end else begin
            out_a_d = mod_add(side_q[RED_IDX], red_dout);
            out_b_d = mod_sub(side_q[RED_IDX], red_dout);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_a_q <= '0;
         out_b_q <= '0;
         flag_q  <= 1'b0;
      end else begin
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
         flag_q  <= flag_d;
      end
   end

   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign Dout_flag = flag_q;

endmodule

// File: tb/tb_bfly_25_unified.sv
// Self-checking bench for bfly_25_unified: directed vector table, reset
// sequences, and randomized traffic scored against a big-integer model.
module tb_bfly_25_unified;

   localparam longint unsigned QM = 64'd33292289;

   logic        clk;
   logic        rst;
   logic        en;
   logic        mode;
   logic [24:0] a_in;
   logic [24:0] b_in;
   logic [24:0] w_in;
   logic [24:0] out_a;
   logic [24:0] out_b;
   logic        Dout_flag;

   int n_checks = 0;
   int n_err    = 0;
   int edge_cnt = 0;
   bit mon_en   = 1'b0;
   bit mon_ef;
   bit mon_erf;

   typedef struct {
      int              due;
      longint unsigned ea;
      longint unsigned eb;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      bit              mode;
      longint unsigned a;
      longint unsigned b;
      longint unsigned w;
      longint unsigned ea;
      longint unsigned eb;
   } vec_t;
   vec_t vecs [8];

   bfly_25_unified dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .a_in      (a_in),
      .b_in      (b_in),
      .w_in      (w_in),
      .out_a     (out_a),
      .out_b     (out_b),
      .Dout_flag (Dout_flag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input longint unsigned got,
                        input longint unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, edge_cnt);
      end
   endtask

   // Butterfly straight from the mathematical definition
   function automatic void model(input bit m, input longint unsigned a, input longint unsigned b,
                                 input longint unsigned w, output longint unsigned ea,
                                 output longint unsigned eb);
      longint unsigned p;
      if (!m) begin
         p  = (b * w) % QM;
         ea = (a + p) % QM;
         eb = (a + QM - p) % QM;
      end else begin
         ea = (a + b) % QM;
         eb = (((a + QM - b) % QM) * w) % QM;
      end
   endfunction

   function automatic longint unsigned rnd_coef();
      case ($urandom_range(0, 9))
         0:       return 0;
         1:       return QM - 1;
         default: return longint'($urandom_range(0, 33292288));
      endcase
   endfunction

   task automatic apply(input bit e, input bit m, input longint unsigned a,
                        input longint unsigned b, input longint unsigned w);
      exp_t x;
      @(negedge clk);
      en   = e;
      mode = m;
      a_in = a[24:0];
      b_in = b[24:0];
      w_in = w[24:0];
      if (e && mon_en) begin
         model(m, a, b, w, x.ea, x.eb);
         x.due = edge_cnt + 9;
         sb.push_back(x);
      end
   endtask

   // Scoreboard monitor: flag timing, reducer flag alignment, data, zeroing
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         mon_ef  = (sb.size() > 0) && (sb[0].due == edge_cnt);
         mon_erf = 1'b0;
         foreach (sb[i]) if (sb[i].due == edge_cnt + 1) mon_erf = 1'b1;
         check("dout_flag", 64'(Dout_flag), 64'(mon_ef));
         check("reduc_flag", 64'(dut.u_reduc.Dout_flag), 64'(mon_erf));
         if (mon_ef) begin
            check("out_a", 64'(out_a), sb[0].ea);
            check("out_b", 64'(out_b), sb[0].eb);
            void'(sb.pop_front());
         end else begin
            check("out_a_idle_zero", 64'(out_a), 0);
            check("out_b_idle_zero", 64'(out_b), 0);
         end
         if (sb.size() > 0 && sb[0].due < edge_cnt) begin
            check("missed_sample_due", 64'(edge_cnt), 64'(sb[0].due));
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      mode = 1'b0;
      a_in = '0;
      b_in = '0;
      w_in = '0;

      // Directed table (expected values worked by hand)
      vecs[0] = '{0, 5, 3, 2, 11, 33292288};
      vecs[1] = '{1, 5, 3, 2, 8, 4};
      vecs[2] = '{1, 33292288, 2, 1, 1, 33292286};
      vecs[3] = '{0, 0, 33292288, 33292288, 1, 33292288};
      vecs[4] = '{0, 10, 0, 7, 10, 10};
      vecs[5] = '{1, 0, 1, 1, 1, 33292288};
      vecs[6] = '{0, 100, 16777216, 2, 262243, 33030246};
      vecs[7] = '{1, 7, 7, 12345, 14, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_flag", 64'(Dout_flag), 0);
      check("reset_out_a", 64'(out_a), 0);
      check("reset_out_b", 64'(out_b), 0);
      check("reset_reduc_flag", 64'(dut.u_reduc.Dout_flag), 0);
      rst = 1'b0;

      // Single isolated samples: pulse exactly 9 clocks later, one cycle wide
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].w);
         for (int k = 1; k <= 11; k++) begin
            apply(1'b0, 1'b0, 0, 0, 0);
            if (k == 9) begin
               check("vec_flag", 64'(Dout_flag), 1);
               check("vec_out_a", 64'(out_a), vecs[i].ea);
               check("vec_out_b", 64'(out_b), vecs[i].eb);
            end else begin
               check("vec_flag_low", 64'(Dout_flag), 0);
            end
         end
      end

      // 16 back-to-back samples alternating CT/GS
      mon_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         apply(1'b1, i[0], rnd_coef(), rnd_coef(), rnd_coef());
      end
      repeat (12) apply(1'b0, 1'b0, 0, 0, 0);

      // Async reset while outputs are live
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, i[0], rnd_coef(), rnd_coef(), rnd_coef());
      end
      #2;
      rst = 1'b1;
      en  = 1'b0;
      sb.delete();
      #1;
      check("rst_live_flag", 64'(Dout_flag), 0);
      check("rst_live_out_a", 64'(out_a), 0);
      check("rst_live_out_b", 64'(out_b), 0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (12) apply(1'b0, 1'b0, 0, 0, 0);

      // 4 samples, async reset asserted mid-cycle during the 4th
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, i[0], rnd_coef(), rnd_coef(), rnd_coef());
      end
      #2;
      rst = 1'b1;
      en  = 1'b0;
      sb.delete();
      #1;
      check("rst_early_flag", 64'(Dout_flag), 0);
      check("rst_early_out_a", 64'(out_a), 0);
      check("rst_early_out_b", 64'(out_b), 0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (12) apply(1'b0, 1'b0, 0, 0, 0);

      // Random traffic, random mode, ~70% enable duty
      for (int i = 0; i < 3000; i++) begin
         apply($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
               rnd_coef(), rnd_coef(), rnd_coef());
      end
      repeat (14) apply(1'b0, 1'b0, 0, 0, 0);
      check("scoreboard_drained", 64'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
